// File: rtl/cprv_pkg.sv
// -----------------------------------------------------------------------------
// cprv_pkg
// Shared constants and types for the cprv writeback path.
//   DATA_WIDTH      : default width of writeback data
//   REG_ADDR_WIDTH  : default register address width (2**N architectural regs)
//   wb_src_e        : identifies a writeback producer (ALU or load return)
//   reg_addr_t      : register address at the default width
// -----------------------------------------------------------------------------
package cprv_pkg;

   localparam int DATA_WIDTH     = 64;
   localparam int REG_ADDR_WIDTH = 5;

   typedef enum logic {
      WB_SRC_ALU  = 1'b0,
      WB_SRC_LOAD = 1'b1
   } wb_src_e;

   typedef logic [REG_ADDR_WIDTH-1:0] reg_addr_t;

endpackage : cprv_pkg

// File: rtl/cprv_scoreboard.sv
// -----------------------------------------------------------------------------
// cprv_scoreboard
// Per-register busy vector. A bit is set when an instruction writing that
// register issues and cleared on the edge where its regfile write commits.
// Ports:
//   clk, rst                     : clock, async active-high reset
//   iss_valid_i/iss_rd_en_i/
//   iss_rd_addr_i                : issue-side destination (set request)
//   iss_ready_o                  : low while the issuing rd is still busy (WAW)
//   clr_en_i/clr_addr_i          : committing regfile write (clear request)
//   q1_addr_i/q2_addr_i          : source register queries
//   q1_busy_o/q2_busy_o          : query results (x0 never busy)
//   busy_o                       : full busy vector, for checking
// -----------------------------------------------------------------------------
module cprv_scoreboard #(
   parameter int ADDR_W = 5
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  iss_valid_i,
   input  logic                  iss_rd_en_i,
   input  logic [ADDR_W-1:0]     iss_rd_addr_i,
   output logic                  iss_ready_o,
   input  logic                  clr_en_i,
   input  logic [ADDR_W-1:0]     clr_addr_i,
   input  logic [ADDR_W-1:0]     q1_addr_i,
   input  logic [ADDR_W-1:0]     q2_addr_i,
   output logic                  q1_busy_o,
   output logic                  q2_busy_o,
   output logic [(2**ADDR_W)-1:0] busy_o
);

   localparam int NUM_REGS = 2**ADDR_W;

   logic [NUM_REGS-1:0] r_busy;
   logic [NUM_REGS-1:0] w_busy_nxt;
   logic                w_iss_rd_nz;
   logic                w_iss_ready;
   logic                w_set_en;

   // Issue gating, set request and source queries.
   always_comb begin
      w_iss_rd_nz = (iss_rd_addr_i != {ADDR_W{1'b0}});
      w_iss_ready = !(iss_rd_en_i && w_iss_rd_nz && r_busy[iss_rd_addr_i]);
      w_set_en    = iss_valid_i && w_iss_ready && iss_rd_en_i && w_iss_rd_nz;
      q1_busy_o   = r_busy[q1_addr_i] && (q1_addr_i != {ADDR_W{1'b0}});
      q2_busy_o   = r_busy[q2_addr_i] && (q2_addr_i != {ADDR_W{1'b0}});
   end

   // Next busy vector: set and clear act per bit, so different registers
   // updated in the same cycle never interfere.
   always_comb begin
      w_busy_nxt = r_busy;
      for (int i = 0; i < NUM_REGS; i++) begin
         w_busy_nxt[i] = (r_busy[i] && !(clr_en_i && (clr_addr_i == ADDR_W'(i))))
                       || (w_set_en && (iss_rd_addr_i == ADDR_W'(i)));
      end
      // x0 is hardwired zero and can never have a pending write.
      w_busy_nxt[0] = 1'b0;
   end

   // Busy vector state.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_busy <= {NUM_REGS{1'b0}};
      end else begin
         r_busy <= w_busy_nxt;
      end
   end

   assign iss_ready_o = w_iss_ready;
   assign busy_o      = r_busy;

endmodule : cprv_scoreboard

// File: rtl/cprv_wb_checker.sv
// -----------------------------------------------------------------------------
// cprv_wb_checker
// Simulation-only protocol checks for the writeback arbiter.
// Ports:
//   clk, rst                 : clock, async active-high reset
//   alu_valid_i/alu_ready_i  : ALU handshake
//   ld_valid_i/ld_ready_i    : load handshake
//   xfer_i/xfer_addr_i       : a writeback transfer and its destination
//   busy_i                   : scoreboard busy vector
// -----------------------------------------------------------------------------
module cprv_wb_checker #(
   parameter int ADDR_W = 5
) (
   input logic                   clk,
   input logic                   rst,
   input logic                   alu_valid_i,
   input logic                   alu_ready_i,
   input logic                   ld_valid_i,
   input logic                   ld_ready_i,
   input logic                   xfer_i,
   input logic [ADDR_W-1:0]      xfer_addr_i,
   input logic [(2**ADDR_W)-1:0] busy_i
);

   // A writeback must target a register with a pending write (x0 exempt).
   a_wb_to_busy: assert property (@(posedge clk) disable iff (rst)
      (xfer_i && (xfer_addr_i != {ADDR_W{1'b0}})) |-> busy_i[xfer_addr_i])
      else $error("cprv_wb_arbiter: writeback to non-busy register %0d", xfer_addr_i);

   // Ready never asserts without the matching valid.
   a_alu_ready_valid: assert property (@(posedge clk) disable iff (rst)
      alu_ready_i |-> alu_valid_i)
      else $error("cprv_wb_arbiter: alu_ready without alu_valid");

   a_ld_ready_valid: assert property (@(posedge clk) disable iff (rst)
      ld_ready_i |-> ld_valid_i)
      else $error("cprv_wb_arbiter: ld_ready without ld_valid");

   // At most one producer granted per cycle.
   a_grant_onehot: assert property (@(posedge clk) disable iff (rst)
      !(alu_ready_i && ld_ready_i))
      else $error("cprv_wb_arbiter: both producers granted");

endmodule : cprv_wb_checker

// File: rtl/cprv_wb_arbiter.sv
// -----------------------------------------------------------------------------
// cprv_wb_arbiter
// Shares the single regfile write port between the ALU and load-return
// producers (round robin under contention) and keeps the busy scoreboard
// used by issue for RAW detection and WAW blocking.
// Ports:
//   clk, rst                           : clock, async active-high reset
//   iss_valid_i/iss_rd_en_i/
//   iss_rd_addr_i/iss_ready_o          : issue destination and WAW gate
//   rs1_addr_i/rs2_addr_i,
//   rs1_busy_o/rs2_busy_o              : source hazard queries
//   alu_valid_i/alu_ready_o/
//   alu_rd_addr_i/alu_rd_data_i        : ALU writeback channel
//   ld_valid_i/ld_ready_o/
//   ld_rd_addr_i/ld_rd_data_i          : load writeback channel
//   rf_wr_en_o/rf_wr_addr_o/
//   rf_wr_data_o                       : registered regfile write port
// -----------------------------------------------------------------------------
module cprv_wb_arbiter #(
   parameter int DATA_WIDTH     = cprv_pkg::DATA_WIDTH,
   parameter int REG_ADDR_WIDTH = cprv_pkg::REG_ADDR_WIDTH
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      iss_valid_i,
   input  logic                      iss_rd_en_i,
   input  logic [REG_ADDR_WIDTH-1:0] iss_rd_addr_i,
   output logic                      iss_ready_o,
   input  logic [REG_ADDR_WIDTH-1:0] rs1_addr_i,
   input  logic [REG_ADDR_WIDTH-1:0] rs2_addr_i,
   output logic                      rs1_busy_o,
   output logic                      rs2_busy_o,
   input  logic                      alu_valid_i,
   output logic                      alu_ready_o,
   input  logic [REG_ADDR_WIDTH-1:0] alu_rd_addr_i,
   input  logic [DATA_WIDTH-1:0]     alu_rd_data_i,
   input  logic                      ld_valid_i,
   output logic                      ld_ready_o,
   input  logic [REG_ADDR_WIDTH-1:0] ld_rd_addr_i,
   input  logic [DATA_WIDTH-1:0]     ld_rd_data_i,
   output logic                      rf_wr_en_o,
   output logic [REG_ADDR_WIDTH-1:0] rf_wr_addr_o,
   output logic [DATA_WIDTH-1:0]     rf_wr_data_o
);

   import cprv_pkg::*;

   localparam int NUM_REGS = 2**REG_ADDR_WIDTH;

   wb_src_e                   r_last_grant;
   logic                      r_wr_en;
   logic [REG_ADDR_WIDTH-1:0] r_wr_addr;
   logic [DATA_WIDTH-1:0]     r_wr_data;

   logic                      w_alu_gnt;
   logic                      w_ld_gnt;
   logic                      w_xfer;
   logic [REG_ADDR_WIDTH-1:0] w_xfer_addr;
   logic [DATA_WIDTH-1:0]     w_xfer_data;
   logic [NUM_REGS-1:0]       w_busy;

   // Round-robin grant: a lone requester wins; under contention the channel
   // not granted last time wins.
   always_comb begin
      w_alu_gnt = 1'b0;
      w_ld_gnt  = 1'b0;
      if (alu_valid_i && ld_valid_i) begin
         if (r_last_grant == WB_SRC_LOAD) begin
            w_alu_gnt = 1'b1;
         end else begin
            w_ld_gnt  = 1'b1;
         end
      end else begin
         w_alu_gnt = alu_valid_i;
         w_ld_gnt  = ld_valid_i;
      end
   end

   // Select the granted channel's payload.
   always_comb begin
      w_xfer = w_alu_gnt || w_ld_gnt;
      if (w_ld_gnt) begin
         w_xfer_addr = ld_rd_addr_i;
         w_xfer_data = ld_rd_data_i;
      end else begin
         w_xfer_addr = alu_rd_addr_i;
         w_xfer_data = alu_rd_data_i;
      end
   end

   // Round-robin pointer, moved only by an actual transfer.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_last_grant <= WB_SRC_LOAD;
      end else if (w_alu_gnt) begin
         r_last_grant <= WB_SRC_ALU;
      end else if (w_ld_gnt) begin
         r_last_grant <= WB_SRC_LOAD;
      end else begin
         r_last_grant <= r_last_grant;
      end
   end

   // Registered write port; x0 writebacks are accepted but never enable a write.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wr_en   <= 1'b0;
         r_wr_addr <= {REG_ADDR_WIDTH{1'b0}};
         r_wr_data <= {DATA_WIDTH{1'b0}};
      end else if (w_xfer) begin
         r_wr_en   <= (w_xfer_addr != {REG_ADDR_WIDTH{1'b0}});
         r_wr_addr <= w_xfer_addr;
         r_wr_data <= w_xfer_data;
      end else begin
         r_wr_en   <= 1'b0;
         r_wr_addr <= r_wr_addr;
         r_wr_data <= r_wr_data;
      end
   end

   // Busy bits clear on the commit edge, so the register reads busy for the
   // whole cycle the write is still in flight to the regfile.
   cprv_scoreboard #(
      .ADDR_W (REG_ADDR_WIDTH)
   ) u_sb (
      .clk           (clk),
      .rst           (rst),
      .iss_valid_i   (iss_valid_i),
      .iss_rd_en_i   (iss_rd_en_i),
      .iss_rd_addr_i (iss_rd_addr_i),
      .iss_ready_o   (iss_ready_o),
      .clr_en_i      (r_wr_en),
      .clr_addr_i    (r_wr_addr),
      .q1_addr_i     (rs1_addr_i),
      .q2_addr_i     (rs2_addr_i),
      .q1_busy_o     (rs1_busy_o),
      .q2_busy_o     (rs2_busy_o),
      .busy_o        (w_busy)
   );

   cprv_wb_checker #(
      .ADDR_W (REG_ADDR_WIDTH)
   ) u_chk (
      .clk         (clk),
      .rst         (rst),
      .alu_valid_i (alu_valid_i),
      .alu_ready_i (alu_ready_o),
      .ld_valid_i  (ld_valid_i),
      .ld_ready_i  (ld_ready_o),
      .xfer_i      (w_xfer),
      .xfer_addr_i (w_xfer_addr),
      .busy_i      (w_busy)
   );

   assign alu_ready_o  = w_alu_gnt;
   assign ld_ready_o   = w_ld_gnt;
   assign rf_wr_en_o   = r_wr_en;
   assign rf_wr_addr_o = r_wr_addr;
   assign rf_wr_data_o = r_wr_data;

endmodule : cprv_wb_arbiter

// File: tb/tb_cprv_wb_arbiter.sv
// -----------------------------------------------------------------------------
// tb_cprv_wb_arbiter
// Directed bench for cprv_wb_arbiter. Inputs change 1 time unit after the
// rising edge; outputs are compared 1 time unit after that.
// -----------------------------------------------------------------------------
module tb_cprv_wb_arbiter;

   logic        clk;
   logic        rst;
   logic        iss_valid_i;
   logic        iss_rd_en_i;
   logic [4:0]  iss_rd_addr_i;
   logic        iss_ready_o;
   logic [4:0]  rs1_addr_i;
   logic [4:0]  rs2_addr_i;
   logic        rs1_busy_o;
   logic        rs2_busy_o;
   logic        alu_valid_i;
   logic        alu_ready_o;
   logic [4:0]  alu_rd_addr_i;
   logic [63:0] alu_rd_data_i;
   logic        ld_valid_i;
   logic        ld_ready_o;
   logic [4:0]  ld_rd_addr_i;
   logic [63:0] ld_rd_data_i;
   logic        rf_wr_en_o;
   logic [4:0]  rf_wr_addr_o;
   logic [63:0] rf_wr_data_o;

   int n_tests;
   int n_fail;

   cprv_wb_arbiter #(
      .DATA_WIDTH     (64),
      .REG_ADDR_WIDTH (5)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .iss_valid_i   (iss_valid_i),
      .iss_rd_en_i   (iss_rd_en_i),
      .iss_rd_addr_i (iss_rd_addr_i),
      .iss_ready_o   (iss_ready_o),
      .rs1_addr_i    (rs1_addr_i),
      .rs2_addr_i    (rs2_addr_i),
      .rs1_busy_o    (rs1_busy_o),
      .rs2_busy_o    (rs2_busy_o),
      .alu_valid_i   (alu_valid_i),
      .alu_ready_o   (alu_ready_o),
      .alu_rd_addr_i (alu_rd_addr_i),
      .alu_rd_data_i (alu_rd_data_i),
      .ld_valid_i    (ld_valid_i),
      .ld_ready_o    (ld_ready_o),
      .ld_rd_addr_i  (ld_rd_addr_i),
      .ld_rd_data_i  (ld_rd_data_i),
      .rf_wr_en_o    (rf_wr_en_o),
      .rf_wr_addr_o  (rf_wr_addr_o),
      .rf_wr_data_o  (rf_wr_data_o)
   );

   // Free-running clock, period 10.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      rst = 1'b0;
   endtask

   task automatic check_rf(input string tag, input logic en, input logic [4:0] addr,
                           input logic [63:0] data);
      check_eq({tag, "_en"}, {63'd0, rf_wr_en_o}, {63'd0, en});
      check_eq({tag, "_addr"}, {59'd0, rf_wr_addr_o}, {59'd0, addr});
      check_eq({tag, "_data"}, rf_wr_data_o, data);
   endtask

   initial begin
      n_tests       = 0;
      n_fail        = 0;
      rst           = 1'b1;
      iss_valid_i   = 1'b0;
      iss_rd_en_i   = 1'b0;
      iss_rd_addr_i = 5'd0;
      rs1_addr_i    = 5'd0;
      rs2_addr_i    = 5'd0;
      alu_valid_i   = 1'b0;
      alu_rd_addr_i = 5'd0;
      alu_rd_data_i = 64'd0;
      ld_valid_i    = 1'b0;
      ld_rd_addr_i  = 5'd0;
      ld_rd_data_i  = 64'd0;
      tick();
      tick();
      rst = 1'b0;

      // Reset then idle.
      rs1_addr_i    = 5'd5;
      rs2_addr_i    = 5'd5;
      iss_rd_en_i   = 1'b1;
      iss_rd_addr_i = 5'd5;
      settle();
      check_rf("rst", 1'b0, 5'd0, 64'd0);
      check_eq("rst_rs1_busy", {63'd0, rs1_busy_o}, 64'd0);
      check_eq("rst_rs2_busy", {63'd0, rs2_busy_o}, 64'd0);
      check_eq("rst_iss_ready", {63'd0, iss_ready_o}, 64'd1);
      check_eq("rst_alu_ready", {63'd0, alu_ready_o}, 64'd0);
      check_eq("rst_ld_ready", {63'd0, ld_ready_o}, 64'd0);

      // Issue rd=7, then ALU writeback of 0xDEADBEEF.
      iss_valid_i   = 1'b1;
      iss_rd_addr_i = 5'd7;
      rs1_addr_i    = 5'd7;
      settle();
      check_eq("iss7_ready", {63'd0, iss_ready_o}, 64'd1);
      check_eq("iss7_no_bypass", {63'd0, rs1_busy_o}, 64'd0);
      tick();
      iss_valid_i   = 1'b0;
      iss_rd_en_i   = 1'b0;
      alu_valid_i   = 1'b1;
      alu_rd_addr_i = 5'd7;
      alu_rd_data_i = 64'hDEAD_BEEF;
      settle();
      check_eq("busy7_set", {63'd0, rs1_busy_o}, 64'd1);
      check_eq("alu7_ready", {63'd0, alu_ready_o}, 64'd1);
      check_eq("alu7_ld_ready", {63'd0, ld_ready_o}, 64'd0);
      tick();
      alu_valid_i = 1'b0;
      settle();
      check_rf("wr7", 1'b1, 5'd7, 64'hDEAD_BEEF);
      check_eq("busy7_commit", {63'd0, rs1_busy_o}, 64'd1);
      tick();
      check_eq("wr7_done_en", {63'd0, rf_wr_en_o}, 64'd0);
      check_eq("busy7_clear", {63'd0, rs1_busy_o}, 64'd0);

      // Contention from reset: ALU first, then LD, then ALU again.
      do_reset();
      iss_valid_i   = 1'b1;
      iss_rd_en_i   = 1'b1;
      iss_rd_addr_i = 5'd3;
      tick();
      iss_rd_addr_i = 5'd4;
      tick();
      iss_rd_addr_i = 5'd5;
      tick();
      iss_valid_i   = 1'b0;
      iss_rd_en_i   = 1'b0;
      alu_valid_i   = 1'b1;
      alu_rd_addr_i = 5'd3;
      alu_rd_data_i = 64'd1;
      ld_valid_i    = 1'b1;
      ld_rd_addr_i  = 5'd4;
      ld_rd_data_i  = 64'd2;
      rs1_addr_i    = 5'd3;
      rs2_addr_i    = 5'd4;
      settle();
      check_eq("c1_alu_ready", {63'd0, alu_ready_o}, 64'd1);
      check_eq("c1_ld_ready", {63'd0, ld_ready_o}, 64'd0);
      check_eq("c1_busy3", {63'd0, rs1_busy_o}, 64'd1);
      check_eq("c1_busy4", {63'd0, rs2_busy_o}, 64'd1);
      tick();
      alu_rd_addr_i = 5'd5;
      alu_rd_data_i = 64'd3;
      settle();
      check_eq("c2_alu_ready", {63'd0, alu_ready_o}, 64'd0);
      check_eq("c2_ld_ready", {63'd0, ld_ready_o}, 64'd1);
      check_rf("c2_wr3", 1'b1, 5'd3, 64'd1);
      tick();
      ld_valid_i = 1'b0;
      settle();
      check_eq("c3_alu_ready", {63'd0, alu_ready_o}, 64'd1);
      check_rf("c3_wr4", 1'b1, 5'd4, 64'd2);
      check_eq("c3_busy3", {63'd0, rs1_busy_o}, 64'd0);
      check_eq("c3_busy4", {63'd0, rs2_busy_o}, 64'd1);
      tick();
      alu_valid_i = 1'b0;
      settle();
      check_rf("c4_wr5", 1'b1, 5'd5, 64'd3);
      check_eq("c4_busy4", {63'd0, rs2_busy_o}, 64'd0);
      tick();
      check_eq("c5_en", {63'd0, rf_wr_en_o}, 64'd0);

      // WAW block on rd=9.
      iss_valid_i   = 1'b1;
      iss_rd_en_i   = 1'b1;
      iss_rd_addr_i = 5'd9;
      settle();
      check_eq("waw_first_ready", {63'd0, iss_ready_o}, 64'd1);
      tick();
      iss_valid_i = 1'b0;
      settle();
      check_eq("waw_blocked", {63'd0, iss_ready_o}, 64'd0);
      iss_rd_addr_i = 5'd0;
      settle();
      check_eq("waw_x0_ready", {63'd0, iss_ready_o}, 64'd1);
      iss_rd_addr_i = 5'd9;
      iss_rd_en_i   = 1'b0;
      settle();
      check_eq("waw_no_rd_ready", {63'd0, iss_ready_o}, 64'd1);
      iss_rd_en_i   = 1'b1;
      alu_valid_i   = 1'b1;
      alu_rd_addr_i = 5'd9;
      alu_rd_data_i = 64'h99;
      settle();
      check_eq("waw_xfer_blocked", {63'd0, iss_ready_o}, 64'd0);
      tick();
      alu_valid_i = 1'b0;
      settle();
      check_rf("waw_wr9", 1'b1, 5'd9, 64'h99);
      check_eq("waw_commit_blocked", {63'd0, iss_ready_o}, 64'd0);
      tick();
      check_eq("waw_released", {63'd0, iss_ready_o}, 64'd1);
      iss_rd_en_i = 1'b0;

      // x0 writeback and x0 issue: accepted, no write, no busy.
      iss_valid_i   = 1'b1;
      iss_rd_en_i   = 1'b1;
      iss_rd_addr_i = 5'd0;
      ld_valid_i    = 1'b1;
      ld_rd_addr_i  = 5'd0;
      ld_rd_data_i  = 64'd5;
      rs1_addr_i    = 5'd0;
      settle();
      check_eq("x0_ld_ready", {63'd0, ld_ready_o}, 64'd1);
      tick();
      iss_valid_i = 1'b0;
      iss_rd_en_i = 1'b0;
      ld_valid_i  = 1'b0;
      settle();
      check_eq("x0_no_wr", {63'd0, rf_wr_en_o}, 64'd0);
      check_eq("x0_not_busy", {63'd0, rs1_busy_o}, 64'd0);

      // Reset mid-operation discards the pending write of rd=2.
      iss_valid_i   = 1'b1;
      iss_rd_en_i   = 1'b1;
      iss_rd_addr_i = 5'd2;
      rs1_addr_i    = 5'd2;
      tick();
      iss_valid_i   = 1'b0;
      iss_rd_en_i   = 1'b0;
      alu_valid_i   = 1'b1;
      alu_rd_addr_i = 5'd2;
      alu_rd_data_i = 64'h22;
      settle();
      check_eq("mid_alu_ready", {63'd0, alu_ready_o}, 64'd1);
      tick();
      alu_valid_i = 1'b0;
      settle();
      check_rf("mid_wr2", 1'b1, 5'd2, 64'h22);
      check_eq("mid_busy2", {63'd0, rs1_busy_o}, 64'd1);
      rst = 1'b1;
      settle();
      check_rf("mid_rst", 1'b0, 5'd0, 64'd0);
      check_eq("mid_rst_busy2", {63'd0, rs1_busy_o}, 64'd0);
      tick();
      rst = 1'b0;
      settle();
      check_eq("post_rst_en", {63'd0, rf_wr_en_o}, 64'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule : tb_cprv_wb_arbiter

// File: doc/cprv_wb_arbiter.md
Name: cprv_wb_arbiter

Overview:
- Shares the single register-file write port between two writeback producers: the ALU result channel and the load-return channel.
- Keeps a per-register busy scoreboard. Issue logic uses it to detect RAW hazards and to block WAW issue.
- Sits between the exec/mem stages and cprv_regfile.
- Drives a registered write port (en/addr/data) into the regfile.

Parameters:
- DATA_WIDTH, 64, width of writeback data.
- REG_ADDR_WIDTH, 5, register address width; the scoreboard holds 2**REG_ADDR_WIDTH entries.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- iss_valid_i  in  1  issue stage presents an instruction.
- iss_rd_en_i  in  1  issued instruction writes rd.
- iss_rd_addr_i  in  REG_ADDR_WIDTH  destination of issued instruction.
- iss_ready_o  out  1  issue may proceed (no WAW conflict).
- rs1_addr_i  in  REG_ADDR_WIDTH  source 1 query address.
- rs2_addr_i  in  REG_ADDR_WIDTH  source 2 query address.
- rs1_busy_o  out  1  rs1 has a pending write.
- rs2_busy_o  out  1  rs2 has a pending write.
- alu_valid_i  in  1  ALU result available.
- alu_ready_o  out  1  ALU result accepted this cycle.
- alu_rd_addr_i  in  REG_ADDR_WIDTH  ALU destination.
- alu_rd_data_i  in  DATA_WIDTH  ALU result.
- ld_valid_i  in  1  load data available.
- ld_ready_o  out  1  load data accepted this cycle.
- ld_rd_addr_i  in  REG_ADDR_WIDTH  load destination.
- ld_rd_data_i  in  DATA_WIDTH  load data.
- rf_wr_en_o  out  1  regfile write enable.
- rf_wr_addr_o  out  REG_ADDR_WIDTH  regfile write address.
- rf_wr_data_o  out  DATA_WIDTH  regfile write data.

Behaviour:
- Reset (async assert, sync-safe deassert):
  - all busy bits 0.
  - rf_wr_en_o=0, rf_wr_addr_o=0, rf_wr_data_o=0.
  - Round-robin pointer last_grant=LOAD, so ALU wins the first contention.
- Reset mid-operation discards any pending rf write and clears the scoreboard; producers must re-present.
- Arbitration (combinational):
  - Exactly one valid: that channel is granted.
  - Both valid: grant the channel that was NOT last granted.
  - alu_ready_o / ld_ready_o equal their grant and never assert without the matching valid.
  - Transfer = valid & ready. last_grant updates only on a transfer.
- Producers hold valid/addr/data stable until ready.
- Throughput: one transfer per cycle. Under continuous contention the grants alternate ALU, LD, ALU, ...
- Write port: transfer at edge N, then rf_wr_en_o=1 with the registered addr/data during cycle N..N+1; the regfile commits at edge N+1.
- A transfer to x0 is accepted (ready high) but leaves rf_wr_en_o=0. It has no scoreboard effect.
- Scoreboard set: iss_valid_i & iss_ready_o & iss_rd_en_i & iss_rd_addr_i!=0 sets busy[rd] at the next edge.
- Scoreboard clear: busy[rf_wr_addr_o] clears at the edge where rf_wr_en_o=1 commits. Busy therefore stays visible through the commit cycle, so no reader sees a stale regfile value.
- iss_ready_o = !(iss_rd_en_i & iss_rd_addr_i!=0 & busy[iss_rd_addr_i]). It does not depend on iss_valid_i.
- Set and clear can never hit the same register in one cycle (the issue is blocked while busy). Set and clear on different registers in the same cycle are independent.
- rsN_busy_o = busy[rsN_addr_i] & rsN_addr_i!=0. Combinational, with no bypass of same-cycle sets.
- x0 is never busy.
- A writeback to a non-busy register is a protocol violation: simulation assertion only; the write is still performed.
- Both producers targeting the same rd is allowed by arbitration but cannot occur under a legal issue (WAW blocked).

Decomposition:
- Shared package cprv_pkg holds:
  - DATA_WIDTH and REG_ADDR_WIDTH constants.
  - typedef enum logic {WB_SRC_ALU, WB_SRC_LOAD} wb_src_e, used for last_grant.
  - typedef logic [REG_ADDR_WIDTH-1:0] reg_addr_t.
- One sub-module: cprv_scoreboard.
  - Holds the busy vector with set/clear ports and two combinational query ports.
  - Gives the x0 masking and the iss_ready computation.
- The arbiter and write register stay in the top.

Test Plan:
- Reset then idle: all outputs 0; rs1_addr=5 gives rs1_busy_o=0; iss_ready_o=1 for rd=5.
- Issue rd=7, then ALU writeback rd=7 data=64'hDEAD_BEEF.
  - busy[7]=1 from the cycle after issue; alu_ready_o=1 the same cycle as valid.
  - Next cycle rf_wr_en_o=1, addr=7, data=DEAD_BEEF.
  - rs1_busy_o(7)=1 during that cycle and 0 the following cycle.
- Issue rd=3 and rd=4; hold alu_valid (rd=3, data=1) and ld_valid (rd=4, data=2) high together from reset.
  - ALU granted first, LD second.
  - rf writes appear as (3,1) then (4,2) on consecutive cycles.
  - Both busy bits clear in order.
- WAW block: rd=9 busy, then iss_rd_en=1, rd=9 gives iss_ready_o=0 until the cycle after the rf write of 9 commits.
  - rd=0 with rd_en=1 always gives iss_ready_o=1.
- x0 writeback: ld_valid, rd=0, data=5 gives ld_ready_o=1, rf_wr_en_o stays 0, and no assertion fires.
- Reset mid-op: busy[2]=1 and an ALU transfer to rd=2 accepted; asserting rst before the commit edge forces rf_wr_en_o=0 and busy[2]=0 immediately (async).
